bram_replicate_arb: RTL and testbench
=====================================

// Module: bram_replicate_arb
// PURPOSE
//  Multi-port BRAM: NUM_READ_CHANNELS identical replicas, each with one private read port; all replicas share one write stream.
//  NUM_WRITE_CHANNELS writers each feed a private write queue. A round-robin arbiter drains the queues, one write per cycle, broadcast to every replica.
//  Replaces single/dual-writer replication: any writer count, backpressure via almostfull, no same-cycle write conflicts.
// PARAMETERS
//  WIDTH              8  data bits per word
//  LOG2_DEPTH         5  BRAM address bits (depth 2**LOG2_DEPTH)
//  NUM_WRITE_CHANNELS 2  writers (>=1)
//  NUM_READ_CHANNELS  3  readers = BRAM replicas (>=1)
//  LOG2_WQ_DEPTH      2  per-writer queue depth 2**LOG2_WQ_DEPTH
//  AF_SLACK           1  almostfull asserted when count >= 2**LOG2_WQ_DEPTH - AF_SLACK
// PORTS
//  clk            in   1                      clock
//  reset          in   1                      async, active-high
//  w_we           in   NW                     write request, per channel
//  w_waddr        in   NW*LOG2_DEPTH          write address, channel i at [i*LOG2_DEPTH +: LOG2_DEPTH]
//  w_wdata        in   NW*WIDTH               write data, channel i at [i*WIDTH +: WIDTH]
//  w_almostfull   out  NW                     queue near full; writer must stop
//  w_count        out  NW*(LOG2_WQ_DEPTH+1)   queue occupancy per channel
//  w_overflow     out  NW                     sticky: a write arrived at a full queue and was dropped
//  r_re           in   NR                     read request, per channel
//  r_raddr        in   NR*LOG2_DEPTH          read address
//  r_rvalid       out  NR                     read data valid
//  r_rdata        out  NR*WIDTH               read data
// BEHAVIOUR
//  Reset (async assert, sync release): all queues empty, w_count=0, w_almostfull=0, w_overflow=0,
//   rr pointer=0, commit stage idle, r_rvalid=0, r_rdata=0. BRAM contents are not cleared.
//   Reset mid-operation discards all queued and in-flight writes. A read issued in the reset cycle returns no rvalid.
//  Enqueue: w_we[i]=1 with count<2**LOG2_WQ_DEPTH pushes {waddr,wdata}. Fullness uses the pre-edge count; there is no pass-through
//   when a pop happens in the same cycle. w_we[i]=1 while full drops the write and sets w_overflow[i] until reset.
//   Simultaneous push and pop leaves count unchanged.
//  Arbiter: combinational grant over non-empty queues, starting at rr pointer, at most one per cycle.
//   On grant g: pop queue g, latch {addr,data} into the commit register, rr pointer <= (g+1) mod NW. No grant leaves the pointer unchanged.
//   Wrap-around: pointer NW-1 advances to 0.
//  Commit: the commit register drives we/waddr/wdata of all replicas in the same cycle. Replicas stay bit-identical at all times.
//  Write latency: w_we at cycle t with an empty queue and the channel granted -> BRAM written at the end of t+2.
//   An r_re at t+3 returns the new data.
//  Fairness: with all NW queues continuously non-empty, each channel gets exactly one grant per NW cycles.
//  Read: r_re[j] at cycle t -> r_rvalid[j]=1 and r_rdata[j]=mem[raddr] at t+1, one-cycle latency, fully pipelined.
//   r_rvalid=0 when no request; r_rdata holds its last value. Readers are independent, with no arbitration or stall.
//  Same-cycle read and commit to the same address: the read returns the old data (read-first).
//  w_almostfull and w_count are registered, updated each edge from the new count.
// CONFIGURATION
//  BRAM_REPLICATE_ARB_FWD_EN defined: read-after-write forwarding.
//   If r_re[j] at t and the commit in t targets r_raddr[j], then r_rdata[j] at t+1 = commit data.
//   Adds one compare and one mux per reader.
//  Undefined: read-first as above; no forwarding logic.
// TESTING
//  1 single write: ch0 w_we, addr 5, data 0xA5 at t0; r_re all readers addr 5 at t0+3 -> every r_rdata=0xA5, r_rvalid=1 at t0+4.
//  2 contention: NW=2, both channels write every cycle for 8 cycles (ch0 addr 0..7, ch1 addr 8..15) -> grants alternate 0,1,0,1.
//    ch0 almostfull asserts at count 3. Ignoring almostfull -> w_overflow=1 and the dropped addresses keep their old values.
//  3 rr wrap: NW=3, only ch2 and ch0 non-empty with pointer=2 -> grant order 2,0,2,0.
//  4 same-address hazard: commit 0x3C to addr 9 while r_re addr 9 (old 0x11) -> 0x11 without FWD_EN, 0x3C with it.
//  5 reset mid-op: 3 entries queued in ch1, assert reset for 1 cycle -> counts 0, no BRAM write afterward, rvalid 0, overflow cleared.
//  6 read throughput: 32 back-to-back reads on 3 readers with random writes -> all rvalid contiguous; data matches the scoreboard model.

Source files
------------

// File: rtl/bram_replicate_arb.sv
// bram_replicate_arb
//
// Multi-port BRAM. NUM_READ_CHANNELS replicas of one memory each give one reader a private read
// port. All replicas share one write stream. Each of the NUM_WRITE_CHANNELS writers pushes into
// its own small write queue. A round-robin arbiter pops at most one queue per cycle into a commit
// register, and that register is written into every replica on the next cycle. This keeps the
// replicas bit-identical.
//
// Ports (NW = NUM_WRITE_CHANNELS, NR = NUM_READ_CHANNELS):
//   clk           in   clock
//   reset         in   asynchronous, active-high
//   w_we          in   [NW]                    per-writer write request
//   w_waddr       in   [NW*LOG2_DEPTH]         writer i at [i*LOG2_DEPTH +: LOG2_DEPTH]
//   w_wdata       in   [NW*WIDTH]              writer i at [i*WIDTH +: WIDTH]
//   w_almostfull  out  [NW]                    registered; writer should stop
//   w_count       out  [NW*(LOG2_WQ_DEPTH+1)]  registered queue occupancy
//   w_overflow    out  [NW]                    sticky; a write hit a full queue and was dropped
//   r_re          in   [NR]                    per-reader read request
//   r_raddr       in   [NR*LOG2_DEPTH]         reader j at [j*LOG2_DEPTH +: LOG2_DEPTH]
//   r_rvalid      out  [NR]                    read data valid, one cycle after r_re
//   r_rdata       out  [NR*WIDTH]              read data; holds its value when not reading
//
// Configuration macro: BRAM_REPLICATE_ARB_FWD_EN
//   Defined:   a read that hits the address being committed in the same cycle returns the
//              commit data (read-after-write forwarding).
//   Undefined: that read returns the old memory contents (read-first).
//
// Write path latency: a write into an empty queue that wins arbitration reaches the memory at the
// end of the second cycle after the request.
// LOG2_WQ_DEPTH must be >= 1.

module bram_replicate_arb #(
  parameter int unsigned WIDTH              = 8,
  parameter int unsigned LOG2_DEPTH         = 5,
  parameter int unsigned NUM_WRITE_CHANNELS = 2,
  parameter int unsigned NUM_READ_CHANNELS  = 3,
  parameter int unsigned LOG2_WQ_DEPTH      = 2,
  parameter int unsigned AF_SLACK           = 1
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NUM_WRITE_CHANNELS-1:0]                       w_we,
  input  logic [NUM_WRITE_CHANNELS*LOG2_DEPTH-1:0]            w_waddr,
  input  logic [NUM_WRITE_CHANNELS*WIDTH-1:0]                 w_wdata,
  output logic [NUM_WRITE_CHANNELS-1:0]                       w_almostfull,
  output logic [NUM_WRITE_CHANNELS*(LOG2_WQ_DEPTH+1)-1:0]     w_count,
  output logic [NUM_WRITE_CHANNELS-1:0]                       w_overflow,
  input  logic [NUM_READ_CHANNELS-1:0]                        r_re,
  input  logic [NUM_READ_CHANNELS*LOG2_DEPTH-1:0]             r_raddr,
  output logic [NUM_READ_CHANNELS-1:0]                        r_rvalid,
  output logic [NUM_READ_CHANNELS*WIDTH-1:0]                  r_rdata
);

  localparam int unsigned NumW    = NUM_WRITE_CHANNELS;
  localparam int unsigned NumR    = NUM_READ_CHANNELS;
  localparam int unsigned Depth   = 2 ** LOG2_DEPTH;
  localparam int unsigned WqDepth = 2 ** LOG2_WQ_DEPTH;
  localparam int unsigned CntW    = LOG2_WQ_DEPTH + 1;
  localparam int unsigned PtrW    = (NumW > 1) ? $clog2(NumW) : 1;
  localparam int unsigned AfLevel = (AF_SLACK >= WqDepth) ? 0 : WqDepth - AF_SLACK;

  // Arbiter <-> queue interface
  logic [NumW-1:0]       q_nonempty;
  logic [NumW-1:0]       gnt_onehot;
  logic [LOG2_DEPTH-1:0] head_addr [NumW];
  logic [WIDTH-1:0]      head_data [NumW];

  logic                  gnt_valid;
  logic [PtrW-1:0]       gnt_idx;
  logic [PtrW-1:0]       rr_q;
  int unsigned           cand;

  // Commit stage shared by all replicas
  logic                  cm_valid_q;
  logic [LOG2_DEPTH-1:0] cm_addr_q;
  logic [WIDTH-1:0]      cm_data_q;

  // ---------------------------------------------------------------------------------------------
  // Per-writer queues
  // ---------------------------------------------------------------------------------------------
  for (genvar i = 0; i < NumW; i++) begin : g_wq
    logic [LOG2_DEPTH-1:0]    qa_mem [WqDepth];
    logic [WIDTH-1:0]         qd_mem [WqDepth];
    logic [LOG2_WQ_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_WQ_DEPTH-1:0] rd_ptr_q;
    logic [CntW-1:0]          cnt_q;
    logic [CntW-1:0]          cnt_d;
    logic                     af_q;
    logic                     ovf_q;
    logic                     full;
    logic                     push;
    logic                     pop;

    // Fullness is judged on the pre-edge count: a pop in the same cycle does not make room.
    assign full = (cnt_q == CntW'(WqDepth));
    assign push = w_we[i] && !full;
    assign pop  = gnt_onehot[i];

    always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    // Queue storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
      if (push) begin
        qa_mem[wr_ptr_q] <= w_waddr[i*LOG2_DEPTH +: LOG2_DEPTH];
        qd_mem[wr_ptr_q] <= w_wdata[i*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        af_q     <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + LOG2_WQ_DEPTH'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + LOG2_WQ_DEPTH'(1);
        end
        cnt_q <= cnt_d;
        af_q  <= (cnt_d >= CntW'(AfLevel));
        if (w_we[i] && full) begin
          ovf_q <= 1'b1;
        end
      end
    end

    assign q_nonempty[i]               = (cnt_q != '0);
    assign head_addr[i]                = qa_mem[rd_ptr_q];
    assign head_data[i]                = qd_mem[rd_ptr_q];
    assign w_count[i*CntW +: CntW]     = cnt_q;
    assign w_almostfull[i]             = af_q;
    assign w_overflow[i]               = ovf_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty queue at or after rr_q, wrapping at NumW.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_idx    = rr_q;
    gnt_onehot = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NumW; k++) begin
      cand = (32'(rr_q) + k) % NumW;
      if (!gnt_valid && q_nonempty[PtrW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PtrW'(cand);
      end
    end
    if (gnt_valid) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves past the winner so it has lowest priority next time; idle cycles hold it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      cm_valid_q <= 1'b0;
      cm_addr_q  <= '0;
      cm_data_q  <= '0;
    end else begin
      cm_valid_q <= gnt_valid;
      if (gnt_valid) begin
        cm_addr_q <= head_addr[gnt_idx];
        cm_data_q <= head_data[gnt_idx];
        rr_q      <= (32'(gnt_idx) == NumW - 1) ? '0 : gnt_idx + PtrW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Replicas: identical write port from the commit stage, private registered read port each.
  // ---------------------------------------------------------------------------------------------
  for (genvar j = 0; j < NumR; j++) begin : g_rep
    logic [WIDTH-1:0]      mem [Depth];
    logic [LOG2_DEPTH-1:0] raddr;
    logic [WIDTH-1:0]      rd_word;
    logic                  rvalid_q;
    logic [WIDTH-1:0]      rdata_q;

    assign raddr = r_raddr[j*LOG2_DEPTH +: LOG2_DEPTH];

    // Contents are never reset; a reset only cancels the in-flight commit.
    always_ff @(posedge clk) begin
      if (cm_valid_q) begin
        mem[cm_addr_q] <= cm_data_q;
      end
    end

`ifdef BRAM_REPLICATE_ARB_FWD_EN
    // Same-cycle commit to the read address is bypassed to the reader.
    assign rd_word = (cm_valid_q && (cm_addr_q == raddr)) ? cm_data_q : mem[raddr];
`else
    // The read samples the array before this cycle's commit lands (read-first).
    assign rd_word = mem[raddr];
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= r_re[j];
        if (r_re[j]) begin
          rdata_q <= rd_word;
        end
      end
    end

    assign r_rvalid[j]                 = rvalid_q;
    assign r_rdata[j*WIDTH +: WIDTH]   = rdata_q;
  end

endmodule

// File: tb/tb_bram_replicate_arb.sv
// Testbench for bram_replicate_arb (WIDTH=8, depth 32, 2 writers, 3 readers, queue depth 4).
// Read expectations are pushed into per-reader queues at issue time; a negedge monitor pops and
// compares whenever a reader presents r_rvalid.

module tb_bram_replicate_arb;

  localparam int NR = 3;

`ifdef BRAM_REPLICATE_ARB_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  w_we;
  logic [9:0]  w_waddr;
  logic [15:0] w_wdata;
  logic [1:0]  w_almostfull;
  logic [5:0]  w_count;
  logic [1:0]  w_overflow;
  logic [2:0]  r_re;
  logic [14:0] r_raddr;
  logic [2:0]  r_rvalid;
  logic [23:0] r_rdata;

  always #5 clk = ~clk;

  bram_replicate_arb #(
    .WIDTH             (8),
    .LOG2_DEPTH        (5),
    .NUM_WRITE_CHANNELS(2),
    .NUM_READ_CHANNELS (3),
    .LOG2_WQ_DEPTH     (2),
    .AF_SLACK          (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .w_we        (w_we),
    .w_waddr     (w_waddr),
    .w_wdata     (w_wdata),
    .w_almostfull(w_almostfull),
    .w_count     (w_count),
    .w_overflow  (w_overflow),
    .r_re        (r_re),
    .r_raddr     (r_raddr),
    .r_rvalid    (r_rvalid),
    .r_rdata     (r_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_mem [32];
  logic [7:0] exp_q [NR][$];
  logic [7:0] mon_e;

  // Contention vectors (both writers every cycle from rr=0, empty queues), hand-computed.
  logic [2:0] exp_c0  [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3};
  logic [2:0] exp_c1  [8] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3, 3'd4};
  logic [1:0] exp_af  [8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [1:0] exp_ovf [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
  logic [7:0] drop0 = 8'b1000_0000;  // ch0 write of cycle 7 hits a full queue
  logic [7:0] drop1 = 8'b0100_0000;  // ch1 write of cycle 6 hits a full queue

  // Random-traffic history
  logic       h_en [32];
  logic [4:0] h_a  [32];
  logic [7:0] h_d  [32];
  logic [4:0] ra;
  logic [7:0] e6;
  int         gaps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_we = '0;
    r_re = '0;
  endtask

  task automatic set_w(input int ch, input logic [4:0] a, input logic [7:0] d);
    w_we[ch]           = 1'b1;
    w_waddr[ch*5 +: 5] = a;
    w_wdata[ch*8 +: 8] = d;
  endtask

  task automatic set_r(input int j, input logic [4:0] a, input logic [7:0] e);
    r_re[j]           = 1'b1;
    r_raddr[j*5 +: 5] = a;
    exp_q[j].push_back(e);
  endtask

  // Monitor: every presented read is matched against the oldest expectation for that reader.
  always @(negedge clk) begin
    for (int j = 0; j < NR; j++) begin
      if (r_rvalid[j]) begin
        if (exp_q[j].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_rvalid_r%0d: got rvalid=1 data 0x%0h, required no rvalid", j,
                   r_rdata[j*8 +: 8]);
        end else begin
          mon_e = exp_q[j].pop_front();
          chk($sformatf("rdata_r%0d", j), 32'(r_rdata[j*8 +: 8]), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    w_we    = '0;
    w_waddr = '0;
    w_wdata = '0;
    r_re    = '0;
    r_raddr = '0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(w_count), 32'd0);
    chk("rst_almostfull", 32'(w_almostfull), 32'd0);
    chk("rst_overflow", 32'(w_overflow), 32'd0);
    chk("rst_rvalid", 32'(r_rvalid), 32'd0);
    chk("rst_rdata", 32'(r_rdata), 32'd0);

    // Fill memory: addr a <- a ^ 0x18 (addr 9 holds 0x11)
    for (int a = 0; a < 32; a++) begin
      idle();
      set_w(0, 5'(a), 8'(a ^ 8'h18));
      model_mem[a] = 8'(a ^ 8'h18);
      tick();
    end
    idle();
    repeat (4) tick();

    // Single write, read at t0+3 on all readers
    set_w(0, 5'd5, 8'hA5);
    tick();
    idle();
    chk("t1_count_after_push", 32'(w_count[2:0]), 32'd1);
    tick();
    chk("t1_count_after_pop", 32'(w_count[2:0]), 32'd0);
    tick();
    model_mem[5] = 8'hA5;
    for (int j = 0; j < NR; j++) set_r(j, 5'd5, 8'hA5);
    tick();
    idle();
    chk("t1_rvalid", 32'(r_rvalid), 32'h7);
    repeat (2) tick();

    // Same-address hazard: read addr 9 in the commit cycle
    set_w(0, 5'd9, 8'h3C);
    tick();
    idle();
    tick();
    set_r(1, 5'd9, Fwd ? 8'h3C : 8'h11);
    tick();
    idle();
    model_mem[9] = 8'h3C;
    set_r(0, 5'd9, 8'h3C);
    tick();
    idle();
    repeat (2) tick();

    // Contention from a clean arbiter state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idle();
      set_w(0, 5'(k), 8'(8'h80 | k));
      set_w(1, 5'(8 + k), 8'(8'hC0 | k));
      if (!drop0[k]) model_mem[k] = 8'(8'h80 | k);
      if (!drop1[k]) model_mem[8 + k] = 8'(8'hC0 | k);
      tick();
      chk($sformatf("t2_count_c%0d", k), 32'(w_count), 32'({exp_c1[k], exp_c0[k]}));
      chk($sformatf("t2_almostfull_c%0d", k), 32'(w_almostfull), 32'(exp_af[k]));
      chk($sformatf("t2_overflow_c%0d", k), 32'(w_overflow), 32'(exp_ovf[k]));
    end
    idle();
    repeat (10) tick();
    chk("t2_drained_count", 32'(w_count), 32'd0);
    chk("t2_overflow_sticky", 32'(w_overflow), 32'h3);
    for (int a = 0; a < 16; a++) begin
      idle();
      for (int j = 0; j < NR; j++) set_r(j, 5'(a), model_mem[a]);
      tick();
    end
    idle();
    repeat (2) tick();

    // Reset mid-operation: ch1 holds 3 entries, one commit in flight
    for (int k = 0; k < 5; k++) begin
      idle();
      set_w(0, 5'(20 + k), 8'(8'h60 + k));
      set_w(1, 5'(25 + k), 8'(8'h70 + k));
      tick();
    end
    idle();
    chk("t5_ch1_count_pre", 32'(w_count[5:3]), 32'd3);
    reset   = 1'b1;
    r_re    = 3'b111;
    r_raddr = {5'd20, 5'd20, 5'd20};
    tick();
    reset = 1'b0;
    idle();
    chk("t5_count_post", 32'(w_count), 32'd0);
    chk("t5_overflow_post", 32'(w_overflow), 32'd0);
    chk("t5_almostfull_post", 32'(w_almostfull), 32'd0);
    chk("t5_rvalid_post", 32'(r_rvalid), 32'd0);
    repeat (4) tick();
    chk("t5_count_idle", 32'(w_count), 32'd0);
    model_mem[20] = 8'h60;
    model_mem[25] = 8'h70;
    model_mem[21] = 8'h61;
    for (int a = 20; a < 30; a++) begin
      idle();
      for (int j = 0; j < NR; j++) set_r(j, 5'(a), model_mem[a]);
      tick();
    end
    idle();
    repeat (2) tick();

    // Back-to-back reads with random single-writer traffic (fixed 2-cycle commit latency)
    gaps = 0;
    for (int r = 0; r < 32; r++) begin
      idle();
      h_en[r] = 1'($urandom_range(0, 1));
      h_a[r]  = 5'($urandom_range(0, 31));
      h_d[r]  = 8'($urandom_range(0, 255));
      if (h_en[r]) set_w(0, h_a[r], h_d[r]);
      if (r >= 3 && h_en[r-3]) model_mem[h_a[r-3]] = h_d[r-3];
      for (int j = 0; j < NR; j++) begin
        ra = 5'($urandom_range(0, 31));
        e6 = model_mem[ra];
        if (Fwd && r >= 2 && h_en[r-2] && (h_a[r-2] == ra)) e6 = h_d[r-2];
        set_r(j, ra, e6);
      end
      tick();
      if (r_rvalid !== 3'b111) gaps++;
    end
    idle();
    chk("t6_rvalid_gaps", 32'(gaps), 32'd0);
    for (int r = 29; r < 32; r++) begin
      if (h_en[r]) model_mem[h_a[r]] = h_d[r];
    end
    repeat (4) tick();
    for (int a = 0; a < 32; a++) begin
      idle();
      set_r(a % NR, 5'(a), model_mem[a]);
      tick();
    end
    idle();
    repeat (3) tick();

    for (int j = 0; j < NR; j++) begin
      chk($sformatf("leftover_expect_r%0d", j), 32'(exp_q[j].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
